// File: rtl/pulse_div_multi.sv
// ---------------------------------------------------------------------------
// pulse_div_multi
//   Multi-channel clock divider / pulse generator. Each channel divides clk_in
//   by a runtime-programmable divisor N and produces a one-cycle tick every N
//   enabled edges plus a square wave that is high ceil(N/2) and low floor(N/2)
//   cycles per period. Divisor writes land in a shadow register and become
//   active only at the channel's period wrap, so no short or long periods are
//   ever produced. A global enable freezes all channels. A global sync
//   realigns every channel to phase 0.
//
// Ports
//   clk_in    in   1        system clock, rising edge
//   rst       in   1        synchronous reset, active low
//   en        in   1        global count enable
//   sync      in   1        realign all channels to phase 0
//   cfg_wr    in   1        divisor write strobe
//   cfg_ch    in   CH_W     channel index for cfg_wr (out-of-range ignored)
//   cfg_div   in   CNT_W    new divisor (0 = channel stopped)
//   tick      out  NUM_CH   one-cycle pulse per channel, period N
//   sq        out  NUM_CH   square wave per channel, period N
//   cfg_busy  out  NUM_CH   divisor write pending for that channel
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// pulse_div_lane
//   One divider channel: phase counter, active and shadow divisors, pending
//   flag and the registered tick/sq outputs.
//
// Ports
//   clk_in  in   1      system clock
//   rst     in   1      synchronous reset, active low
//   en      in   1      count enable
//   sync    in   1      realign to phase 0 and apply pending divisor now
//   wr      in   1      divisor write addressed to this lane
//   wdiv    in   CNT_W  divisor being written
//   tick    out  1      one-cycle pulse at period wrap
//   sq      out  1      square wave
//   busy    out  1      shadow divisor waiting for the next wrap
// ---------------------------------------------------------------------------
module pulse_div_lane #(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] RST_DIV = '0
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wdiv,
    output logic             tick,
    output logic             sq,
    output logic             busy
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_sh;
    logic             pending;

    logic             wrap;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] div_nxt;
    logic [CNT_W-1:0] half_nxt;

    // The square-wave threshold follows the divisor that will be active for
    // the period starting after this edge, so a switch to N=0 at a wrap
    // drops sq immediately instead of leaving a one-cycle high blip.
    always_comb begin
        wrap     = (div_act != '0) && (cnt == div_act - ONE);
        cnt_nxt  = wrap ? '0 : cnt + ONE;
        div_nxt  = (wrap && pending) ? div_sh : div_act;
        half_nxt = (div_nxt >> 1) + CNT_W'(div_nxt[0]);
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            cnt     <= '0;
            div_act <= RST_DIV;
            div_sh  <= RST_DIV;
            pending <= 1'b0;
            tick    <= 1'b0;
            sq      <= 1'b0;
        end else if (sync) begin
            // Phase realign: a write on this same edge bypasses the shadow
            // and goes straight to the active divisor.
            cnt     <= '0;
            tick    <= 1'b0;
            sq      <= 1'b0;
            pending <= 1'b0;
            if (wr) begin
                div_act <= wdiv;
                div_sh  <= wdiv;
            end else if (pending) begin
                div_act <= div_sh;
            end
        end else begin
            if (div_act == '0) begin
                // Stopped channel: nothing to wait for, apply at once.
                cnt  <= '0;
                tick <= 1'b0;
                sq   <= 1'b0;
                if (pending) begin
                    div_act <= div_sh;
                    pending <= 1'b0;
                end
            end else if (en) begin
                cnt  <= cnt_nxt;
                tick <= wrap;
                sq   <= (cnt_nxt < half_nxt);
                if (wrap && pending) begin
                    div_act <= div_sh;
                    pending <= 1'b0;
                end
            end else begin
                tick <= 1'b0;
            end
            // Placed last so a write coinciding with a wrap survives as the
            // next pending value while the older shadow is applied above.
            if (wr) begin
                div_sh  <= wdiv;
                pending <= 1'b1;
            end
        end
    end

    assign busy = pending;

endmodule

module pulse_div_multi #(
    parameter int                      NUM_CH  = 2,
    parameter int                      CNT_W   = 16,
    parameter logic [NUM_CH*CNT_W-1:0] RST_DIV = {16'd200, 16'd100},
    localparam int                     CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              en,
    input  logic              sync,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] cfg_busy
);

    logic [NUM_CH-1:0] wr;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        // An index at or beyond NUM_CH matches no lane, so the write is dropped.
        assign wr[i] = cfg_wr && (32'(cfg_ch) == i);

        pulse_div_lane #(
            .CNT_W   (CNT_W),
            .RST_DIV (RST_DIV[i*CNT_W +: CNT_W])
        ) u_lane (
            .clk_in (clk_in),
            .rst    (rst),
            .en     (en),
            .sync   (sync),
            .wr     (wr[i]),
            .wdiv   (cfg_div),
            .tick   (tick[i]),
            .sq     (sq[i]),
            .busy   (cfg_busy[i])
        );
    end

endmodule

// File: tb/tb_pulse_div_multi.sv
// ---------------------------------------------------------------------------
// tb_pulse_div_multi
//   Self-checking bench for pulse_div_multi (2 channels, 16-bit, defaults
//   100/200). Every cycle the outputs are compared against a behavioural model
//   that tracks, per channel, how far into its period it is. Directed
//   scenarios additionally measure tick spacing and square-wave duty.
// ---------------------------------------------------------------------------
module tb_pulse_div_multi;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 16;
    localparam int CH_W   = 1;

    logic              clk_in = 1'b0;
    logic              rst    = 1'b0;
    logic              en     = 1'b0;
    logic              sync   = 1'b0;
    logic              cfg_wr = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_div = '0;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic [NUM_CH-1:0] cfg_busy;

    pulse_div_multi #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .RST_DIV ({16'd200, 16'd100})
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .cfg_wr   (cfg_wr),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .tick     (tick),
        .sq       (sq),
        .cfg_busy (cfg_busy)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // model state per channel
    int pos  [NUM_CH];   // enabled edges elapsed in the current period
    int nact [NUM_CH];
    int nsh  [NUM_CH];
    bit pend [NUM_CH];
    bit mt   [NUM_CH];
    bit ms   [NUM_CH];

    // tick spacing bookkeeping
    int lt0 = 0, lt1 = 0;
    int gaps0[$];
    int gaps1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d obs=%0d exp=%0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int rdiv(input int c);
        return (c == 0) ? 100 : 200;
    endfunction

    task automatic model_step(input bit r, input bit e, input bit s, input bit w,
                              input int ch, input int d);
        for (int c = 0; c < NUM_CH; c++) begin
            bit wc;
            wc = w && (ch == c);
            if (!r) begin
                pos[c] = 0; nact[c] = rdiv(c); nsh[c] = rdiv(c);
                pend[c] = 0; mt[c] = 0; ms[c] = 0;
            end else if (s) begin
                pos[c] = 0; mt[c] = 0; ms[c] = 0;
                if (wc) begin nact[c] = d; nsh[c] = d; end
                else if (pend[c]) nact[c] = nsh[c];
                pend[c] = 0;
            end else begin
                if (nact[c] == 0) begin
                    pos[c] = 0; mt[c] = 0; ms[c] = 0;
                    if (pend[c]) begin nact[c] = nsh[c]; pend[c] = 0; end
                end else if (e) begin
                    pos[c]++;
                    mt[c] = (pos[c] == nact[c]);
                    if (mt[c]) begin
                        pos[c] = 0;
                        if (pend[c]) begin nact[c] = nsh[c]; pend[c] = 0; end
                    end
                    ms[c] = (pos[c] < (nact[c] + 1) / 2);
                end else begin
                    mt[c] = 0;
                end
                if (wc) begin nsh[c] = d; pend[c] = 1; end
            end
        end
    endtask

    // Drive one clock cycle of inputs, advance the model, compare outputs.
    task automatic cycle(input bit r, input bit e, input bit s, input bit w,
                         input int ch, input int d);
        logic [NUM_CH-1:0] et, es, eb;
        rst = r; en = e; sync = s; cfg_wr = w;
        cfg_ch = CH_W'(ch); cfg_div = CNT_W'(d);
        @(posedge clk_in);
        model_step(r, e, s, w, ch, d);
        cyc++;
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            et[c] = mt[c]; es[c] = ms[c]; eb[c] = pend[c];
        end
        chk("tick", 32'(tick), 32'(et));
        chk("sq", 32'(sq), 32'(es));
        chk("busy", 32'(cfg_busy), 32'(eb));
        if (tick[0]) begin gaps0.push_back(cyc - lt0); lt0 = cyc; end
        if (tick[1]) begin gaps1.push_back(cyc - lt1); lt1 = cyc; end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle(1, 1, 0, 0, 0, 0);
    endtask

    task automatic wait_t0();
        int k;
        k = 0;
        do begin
            cycle(1, 1, 0, 0, 0, 0);
            k++;
        end while (!tick[0] && k < 300);
        chk("wait_tick0", 32'(tick[0]), 32'd1);
    endtask

    initial begin
        int hi;

        // 1: reset 100 ns, then defaults 100 / 200
        for (int k = 0; k < 10; k++) cycle(0, 1, 0, 0, 0, 0);
        chk("rst_outputs", 32'({tick, sq, cfg_busy}), 32'd0);
        lt0 = cyc; lt1 = cyc;
        gaps0.delete(); gaps1.delete();
        run(450);
        chk("t0_first", 32'(gaps0[0]), 32'd100);
        chk("t0_period", 32'(gaps0[1]), 32'd100);
        chk("t1_first", 32'(gaps1[0]), 32'd200);
        chk("t1_period", 32'(gaps1[1]), 32'd200);
        wait_t0();
        hi = 0;
        for (int k = 0; k < 100; k++) begin
            hi += int'(sq[0]);
            if (k < 99) cycle(1, 1, 0, 0, 0, 0);
        end
        chk("sq0_high_100", 32'(hi), 32'd50);

        // 2: reprogram ch0 to 7 mid-period
        run(30);
        gaps0.delete();
        cycle(1, 1, 0, 1, 0, 7);
        chk("busy_after_wr", 32'(cfg_busy[0]), 32'd1);
        run(150);
        chk("t0_old_period", 32'(gaps0[0]), 32'd100);
        chk("t0_new_period", 32'(gaps0[1]), 32'd7);
        wait_t0();
        hi = 0;
        for (int k = 0; k < 7; k++) begin
            hi += int'(sq[0]);
            if (k < 6) cycle(1, 1, 0, 0, 0, 0);
        end
        chk("sq0_high_7", 32'(hi), 32'd4);

        // 3: en low for 30 cycles mid-period
        wait_t0();
        gaps0.delete();
        run(3);
        for (int k = 0; k < 30; k++) cycle(1, 0, 0, 0, 0, 0);
        run(20);
        chk("t0_gap_en", 32'(gaps0[0]), 32'd37);
        chk("t0_after_en", 32'(gaps0[1]), 32'd7);

        // 4: sync with ch0 back to 100 written on the same edge
        run(5);
        cycle(1, 1, 1, 1, 0, 100);
        chk("busy_sync", 32'(cfg_busy), 32'd0);
        lt0 = cyc; lt1 = cyc;
        gaps0.delete(); gaps1.delete();
        run(250);
        chk("sync_t0", 32'(gaps0[0]), 32'd100);
        chk("sync_t0_2", 32'(gaps0[1]), 32'd100);
        chk("sync_t1", 32'(gaps1[0]), 32'd200);

        // 5: ch1 div 0 then div 1
        cycle(1, 1, 0, 1, 1, 0);
        run(210);
        chk("ch1_stopped", 32'({tick[1], sq[1], cfg_busy[1]}), 32'd0);
        cycle(1, 1, 0, 1, 1, 1);
        chk("ch1_busy1", 32'(cfg_busy[1]), 32'd1);
        run(2);
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1, 1, 0, 0, 0, 0);
            hi += int'(tick[1] & sq[1]);
        end
        chk("ch1_div1_const", 32'(hi), 32'd20);

        // 6: reset mid-period with a write pending
        run(13);
        cycle(1, 1, 0, 1, 0, 9);
        for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0, 0, 0);
        chk("rst_mid", 32'({tick, sq, cfg_busy}), 32'd0);
        lt0 = cyc; lt1 = cyc;
        gaps0.delete(); gaps1.delete();
        run(210);
        chk("rst_t0", 32'(gaps0[0]), 32'd100);
        chk("rst_t1", 32'(gaps1[0]), 32'd200);

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            bit r, e, s, w;
            int d, sel;
            r = ($urandom_range(0, 199) != 0);
            e = ($urandom_range(0, 7) != 0);
            s = ($urandom_range(0, 99) == 0);
            w = ($urandom_range(0, 19) == 0);
            sel = $urandom_range(0, 11);
            d = (sel == 10) ? 100 : (sel == 11) ? 200 : sel;
            cycle(r, e, s, w, $urandom_range(0, 1), d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
